hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, giving the multiply/divide occupancy in cycles (legal range 2..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have ports rs, rt, input, 5 each, ID-stage source register numbers.
REQ-005 SHALL have ports IdUseRs, IdUseRt, input, 1 each, ID instruction actually reads rs/rt.
REQ-006 SHALL have port IdBranch, input, 1, ID instruction is a branch compared in ID.
REQ-007 SHALL have ports IdMulStart, IdUseHiLo, input, 1 each, ID instruction starts mult/div or reads HI/LO.
REQ-008 SHALL have ports ExAw, MemAw, input, 5 each, and ExRegWr, ExMemRd, MemMemRd, input, 1 each, describing the EX and MEM destinations.
REQ-009 SHALL have port BranchTaken, input, 1, ID branch resolved taken.
REQ-010 SHALL have ports PcWr, IfIdWr, output, 1 each, PC and IF/ID write enables.
REQ-011 SHALL have ports IdExFlush, IfIdFlush, output, 1 each, bubble into ID/EX and squash of IF/ID.
REQ-012 SHALL have port MulBusy, output, 1, mult/div unit occupied.

Function
REQ-013 Source match: rs (rt) matches register X only when IdUseRs (IdUseRt) = 1, the number equals X, and it is nonzero.
REQ-014 Required stall length N for the current ID instruction, taking the maximum of all applicable terms: load in EX (ExMemRd = 1) matched -> 1; with IdBranch = 1: load in EX matched -> 2, ALU write in EX (ExRegWr = 1, ExMemRd = 0) matched -> 1, load in MEM (MemMemRd = 1) matched -> 1; otherwise 0.
REQ-015 FSM states RUN and HOLD, with a 2-bit remaining-stall counter scnt.
REQ-016 In RUN with N > 0: stall this cycle; if N = 2, go to HOLD with scnt = 1; otherwise stay in RUN.
REQ-017 In HOLD: stall this cycle unconditionally, ignoring REQ-014; decrement scnt; return to RUN when scnt reaches 0.
REQ-018 Stall cycle means PcWr = 0, IfIdWr = 0, IdExFlush = 1, IfIdFlush = 0.
REQ-019 Mult counter mcnt (3 bits): MulBusy = (mcnt != 0); mcnt decrements by 1 per cycle while nonzero, saturating at 0.
REQ-020 IdMulStart = 1 or IdUseHiLo = 1 while MulBusy = 1 SHALL cause a stall cycle in RUN; this is a structural hazard, and HOLD is not entered for it.
REQ-021 IdMulStart = 1 in a non-stall cycle SHALL load mcnt = MUL_LAT at the next edge; an IdMulStart that is stalled SHALL NOT load mcnt.
REQ-022 Non-stall cycle: PcWr = 1, IfIdWr = 1, IdExFlush = 0, IfIdFlush = BranchTaken.
REQ-023 A stall suppresses BranchTaken: IfIdFlush = 0 in any stall cycle.
REQ-024 Outputs are combinational from current inputs and registered state only; there is no added latency. Stall assertion coincides with the detecting cycle.
REQ-025 MUL_LAT counting applies regardless of load/branch stalls; mcnt decrements during HOLD.

Reset
REQ-026 While rst = 1 at the edge: state = RUN, scnt = 0, mcnt = 0.
REQ-027 In the cycle rst = 1 is asserted, outputs SHALL read PcWr = 1, IfIdWr = 1, IdExFlush = 0, IfIdFlush = 0, MulBusy = 0, forced regardless of inputs.
REQ-028 Reset during HOLD or during mult occupancy SHALL abandon the stall and occupancy immediately, with no residual stall cycles.

Verification
REQ-029 Load-use: ExMemRd = 1, ExAw = 8, rs = 8, IdUseRs = 1 -> one cycle PcWr = 0, IdExFlush = 1; next cycle (load now in MEM, no branch) PcWr = 1.
REQ-030 Branch after load: IdBranch = 1, rt = 9, ExMemRd = 1, ExAw = 9 -> exactly 2 stall cycles (RUN to HOLD to RUN), then IfIdFlush = BranchTaken = 1 in the third cycle.
REQ-031 Zero register: ExMemRd = 1, ExAw = 0, rs = 0, IdUseRs = 1 -> no stall.
REQ-032 Mult: IdMulStart = 1 at cycle 0, then IdUseHiLo = 1 at cycle 1 with MUL_LAT = 4 -> stall in cycles 1-4, MulBusy = 1 in cycles 1-4, released in cycle 5.
REQ-033 Simultaneous events: BranchTaken = 1 during a load-use stall -> IfIdFlush = 0; the branch is flushed only in the first non-stall cycle.
REQ-034 Reset mid-HOLD and mid-mult: rst = 1 in the first HOLD cycle with mcnt = 3 -> the next cycle has no stall and MulBusy = 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath side (master) drives the ID/EX/MEM descriptors; the controller (slave) drives the enables.
interface hazard_ctrl_if;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       IdUseRs;
    logic       IdUseRt;
    logic       IdBranch;
    logic       IdMulStart;
    logic       IdUseHiLo;
    logic [4:0] ExAw;
    logic [4:0] MemAw;
    logic       ExRegWr;
    logic       ExMemRd;
    logic       MemMemRd;
    logic       BranchTaken;
    logic       PcWr;
    logic       IfIdWr;
    logic       IdExFlush;
    logic       IfIdFlush;
    logic       MulBusy;

    modport master (
        output rs, rt, IdUseRs, IdUseRt, IdBranch, IdMulStart, IdUseHiLo,
        output ExAw, MemAw, ExRegWr, ExMemRd, MemMemRd, BranchTaken,
        input  PcWr, IfIdWr, IdExFlush, IfIdFlush, MulBusy
    );

    modport slave (
        input  rs, rt, IdUseRs, IdUseRt, IdBranch, IdMulStart, IdUseHiLo,
        input  ExAw, MemAw, ExRegWr, ExMemRd, MemMemRd, BranchTaken,
        output PcWr, IfIdWr, IdExFlush, IfIdFlush, MulBusy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-compare data stalls plus
// mult/div structural stalls, with stall decisions made in the detecting cycle.
module hazard_ctrl #(
    parameter int MUL_LAT = 4
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t     state_q, state_d;
    logic [1:0] scnt_q, scnt_d;
    logic [2:0] mcnt_q, mcnt_d;

    logic       rs_ex, rt_ex, rs_mem, rt_mem;
    logic       ex_match, mem_match;
    logic [1:0] need;
    logic       mul_busy;
    logic       stall;

    // Register zero never carries a dependency, and unused source fields are ignored.
    always_comb begin
        rs_ex     = bus.IdUseRs && (bus.rs == bus.ExAw)  && (bus.rs != 5'd0);
        rt_ex     = bus.IdUseRt && (bus.rt == bus.ExAw)  && (bus.rt != 5'd0);
        rs_mem    = bus.IdUseRs && (bus.rs == bus.MemAw) && (bus.rs != 5'd0);
        rt_mem    = bus.IdUseRt && (bus.rt == bus.MemAw) && (bus.rt != 5'd0);
        ex_match  = rs_ex || rt_ex;
        mem_match = rs_mem || rt_mem;
        mul_busy  = (mcnt_q != 3'd0);
    end

    // Branches compare in ID, so they also wait on ALU results in EX and loads in MEM.
    always_comb begin
        need = 2'd0;
        if (bus.ExMemRd && ex_match) begin
            need = 2'd1;
        end
        if (bus.IdBranch) begin
            if (bus.ExMemRd && ex_match) begin
                need = 2'd2;
            end else if ((bus.ExRegWr && ex_match) || (bus.MemMemRd && mem_match)) begin
                need = 2'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        mcnt_d  = mul_busy ? (mcnt_q - 3'd1) : 3'd0;
        stall   = 1'b0;

        unique case (state_q)
            RUN: begin
                stall = (need != 2'd0) || (mul_busy && (bus.IdMulStart || bus.IdUseHiLo));
                if (need == 2'd2) begin
                    state_d = HOLD;
                    scnt_d  = 2'd1;
                end
            end
            HOLD: begin
                stall  = 1'b1;
                scnt_d = scnt_q - 2'd1;
                if (scnt_q <= 2'd1) begin
                    state_d = RUN;
                    scnt_d  = 2'd0;
                end
            end
        endcase

        // A stalled mult start is re-presented later, so only an issued one arms the counter.
        if (!stall && bus.IdMulStart) begin
            mcnt_d = 3'(MUL_LAT);
        end
    end

    // Reset forces a free-running pipeline in the very cycle it is asserted.
    always_comb begin
        bus.PcWr      = rst || !stall;
        bus.IfIdWr    = rst || !stall;
        bus.IdExFlush = !rst && stall;
        bus.IfIdFlush = !rst && !stall && bus.BranchTaken;
        bus.MulBusy   = !rst && mul_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            scnt_q  <= 2'd0;
            mcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

endmodule
